piano_voice_sched: RTL and testbench
====================================

// Module: piano_voice_sched
// PURPOSE
//  Monophonic voice scheduler for the simple piano: synchronises and debounces the 8 key
//  inputs, arbitrates simultaneous presses (last-pressed wins), and programs the tone
//  generator's half-period counter via a load/ack handshake. Sits between ui_in and tone_gen.
// PARAMETERS
//  NUM_KEYS    8      number of key inputs (table in package sized to match)
//  CNT_W       16     width of half-period count sent to the tone generator
//  SAMPLE_DIV  10000  clk cycles per debounce sample tick (1 ms @ 10 MHz)
//  DB_SAMPLES  4      consecutive equal samples needed to change a debounced key state
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous active-low reset
//  ena          in   1         design enable; low = synchronous clear of all state
//  keys_i       in   NUM_KEYS  raw key levels, 1 = pressed, asynchronous
//  tone_hp_o    out  CNT_W     half-period count for selected note
//  tone_load_o  out  1         request: tone_hp_o valid, load it
//  tone_ack_i   in   1         tone generator accepted tone_hp_o
//  tone_en_o    out  1         tone generator output gate
//  key_idx_o    out  3         index of sounding key
//  key_vld_o    out  1         key_idx_o valid (a key is sounding)
// BEHAVIOUR
//  - Reset (rst_n=0) or ena=0: all outputs 0, FSM IDLE, debounce state = released, prescaler 0.
//  - keys_i through 2-FF synchroniser; sample tick every SAMPLE_DIV cycles (prescaler wraps
//    SAMPLE_DIV-1 -> 0). Per key: debounced level flips after DB_SAMPLES consecutive ticks
//    sampling the opposite level; any matching sample resets that key's run counter.
//  - Press edge = debounced 0->1. Arbitration (registered, 1 cycle): newest press edge becomes
//    selected key; several edges on same cycle -> highest index wins. If selected key releases,
//    select lowest-index still-held key; none held -> no selection.
//  - FSM: IDLE -> LOAD when a selection exists. LOAD: tone_hp_o = NOTE_HP[sel], tone_load_o=1,
//    go WAIT_ACK. WAIT_ACK: hold tone_load_o and tone_hp_o stable until tone_ack_i=1 (ack
//    sampled same cycle load is high completes it), then PLAY. PLAY: tone_en_o=1,
//    key_vld_o=1, key_idx_o = loaded key. Selection changes in PLAY -> LOAD (tone_en_o stays 1,
//    glide-free retune). No selection in PLAY -> IDLE, tone_en_o=0 next cycle.
//  - Selection change during WAIT_ACK: never abort; finish handshake, then PLAY detects mismatch
//    and reloads. Selection vanishes during WAIT_ACK: finish handshake, then IDLE.
//  - Latency: debounced press -> tone_load_o high in 2 cycles (arbiter reg + LOAD).
//  - tone_ack_i outside WAIT_ACK is ignored. ena falling mid-handshake drops tone_load_o at once.
// STRUCTURE
//  - piano_pkg: NUM_KEYS_DEF, state enum {IDLE, LOAD, WAIT_ACK, PLAY}, NOTE_HP table C4..C5 @
//    10 MHz = {19111,17026,15169,14317,12755,11364,10124,9556}.
//  - Sub-module key_debounce (one key: run counter + debounced level + press/release pulses),
//    instantiated NUM_KEYS times sharing one sample tick.
// TESTING (bench: SAMPLE_DIV=4, DB_SAMPLES=2)
//  1. Reset then keys_i=0 for 100 cycles -> all outputs 0, FSM IDLE.
//  2. keys_i=8'h01 held; ack 1 cycle after load -> tone_hp_o=19111, load high until ack,
//     then tone_en_o=1, key_idx_o=0.
//  3. Key 0 held, press key 5 -> reload tone_hp_o=11364, key_idx_o=5; release 5 -> back to 19111.
//  4. Key 3 glitch high for 3 cycles (< 2 ticks) -> no load, debounced level unchanged.
//  5. Keys 2 and 6 pressed same cycle, ack delayed 10 cycles, key 6 released meanwhile ->
//     tone_hp_o=10124 stable 10 cycles, then reload 15169 for key 2.
//  6. rst_n low mid-WAIT_ACK -> tone_load_o/tone_en_o 0 immediately (async), restart from IDLE.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared types and constants for the piano voice scheduler.
// Provides the FSM state enum, key count and the note half-period table.
package piano_pkg;

  localparam int NUM_KEYS_DEF = 8;
  localparam int HP_W         = 16;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK,
    S_PLAY
  } state_e;

  // Half-period counts for C4..C5 at 10 MHz.
  function automatic logic [HP_W-1:0] note_hp(
    input logic [IDX_W-1:0] idx
  );
    logic [HP_W-1:0] hp;
    unique case (idx)
      3'd0: hp = 16'd19111;
      3'd1: hp = 16'd17026;
      3'd2: hp = 16'd15169;
      3'd3: hp = 16'd14317;
      3'd4: hp = 16'd12755;
      3'd5: hp = 16'd11364;
      3'd6: hp = 16'd10124;
      3'd7: hp = 16'd9556;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/piano_voice_sched_debounce.sv
// key_debounce: one-key debouncer driven by a shared sample tick.
// Ports: clk, rst_n, clr_i (sync clear), tick_i, key_i (synced level),
// level_o (debounced), press_o / release_o (1-cycle edge pulses).
module key_debounce #(
  parameter int DB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int RW = $clog2(DB_SAMPLES + 1);

  logic [RW-1:0] run_q;
  logic          level_q;
  logic          press_q;
  logic          rel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else if (clr_i) begin
      run_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      if (tick_i) begin
        if (key_i == level_q) begin
          run_q <= '0;
        end else if (run_q == RW'(DB_SAMPLES - 1)) begin
          // Last opposite sample of the run: commit.
          run_q   <= '0;
          level_q <= key_i;
          press_q <= key_i;
          rel_q   <= ~key_i;
        end else begin
          run_q <= run_q + 1'b1;
        end
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/piano_voice_sched.sv
// Monophonic voice scheduler: key sync/debounce, last-pressed-wins
// arbitration, and load/ack programming of the tone generator.
// Ports: clk, rst_n, ena, keys_i -> tone_hp_o, tone_load_o, tone_ack_i,
// tone_en_o, key_idx_o, key_vld_o.
module piano_voice_sched
  import piano_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_DEF,
  parameter int CNT_W      = 16,
  parameter int SAMPLE_DIV = 10000,
  parameter int DB_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [CNT_W-1:0]    tone_hp_o,
  output logic                tone_load_o,
  input  logic                tone_ack_i,
  output logic                tone_en_o,
  output logic [IDX_W-1:0]    key_idx_o,
  output logic                key_vld_o
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [PW-1:0]       pre_q;
  logic                tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      pre_q <= '0;
    end else if (!ena) begin
      s1_q  <= '0;
      s2_q  <= '0;
      pre_q <= '0;
    end else begin
      s1_q  <= keys_i;
      s2_q  <= s1_q;
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

  assign tick = (pre_q == PW'(SAMPLE_DIV - 1));

  logic [NUM_KEYS-1:0] lvl, prs, rls;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_db
    key_debounce #(
      .DB_SAMPLES(DB_SAMPLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (~ena),
      .tick_i   (tick),
      .key_i    (s2_q[g]),
      .level_o  (lvl[g]),
      .press_o  (prs[g]),
      .release_o(rls[g])
    );
  end

  logic [IDX_W-1:0] sel_q, sel_d, hi_idx, lo_idx;
  logic             sel_vld_q, sel_vld_d;

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (prs[i]) hi_idx = IDX_W'(i);
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (lvl[i]) lo_idx = IDX_W'(i);
  end

  // Fresh presses beat everything; losing the selected key falls
  // back to the lowest key still held.
  always_comb begin
    sel_d     = sel_q;
    sel_vld_d = sel_vld_q;
    if (|prs) begin
      sel_d     = hi_idx;
      sel_vld_d = 1'b1;
    end else if (sel_vld_q && rls[sel_q]) begin
      sel_d     = lo_idx;
      sel_vld_d = |lvl;
    end
  end

  state_e           state_q;
  logic [CNT_W-1:0] hp_q;
  logic             load_q, en_q, vld_q;
  logic [IDX_W-1:0] idx_q, ld_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
    end else if (!ena) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      sel_vld_q <= sel_vld_d;
    end
  end

  // LOAD is the first cycle the request is visible; an ack there
  // completes the handshake just like in WAIT_ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hp_q     <= '0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      ld_idx_q <= '0;
    end else if (!ena) begin
      state_q  <= S_IDLE;
      hp_q     <= '0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      ld_idx_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sel_vld_q) begin
            state_q  <= S_LOAD;
            load_q   <= 1'b1;
            hp_q     <= CNT_W'(note_hp(sel_q));
            ld_idx_q <= sel_q;
          end
        end
        S_LOAD, S_WAIT_ACK: begin
          if (tone_ack_i) begin
            load_q <= 1'b0;
            if (sel_vld_q) begin
              state_q <= S_PLAY;
              en_q    <= 1'b1;
              vld_q   <= 1'b1;
              idx_q   <= ld_idx_q;
            end else begin
              state_q <= S_IDLE;
              en_q    <= 1'b0;
              vld_q   <= 1'b0;
            end
          end else begin
            state_q <= S_WAIT_ACK;
          end
        end
        S_PLAY: begin
          if (!sel_vld_q) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            vld_q   <= 1'b0;
          end else if (sel_q != idx_q) begin
            state_q  <= S_LOAD;
            load_q   <= 1'b1;
            hp_q     <= CNT_W'(note_hp(sel_q));
            ld_idx_q <= sel_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tone_hp_o   = hp_q;
  assign tone_load_o = load_q;
  assign tone_en_o   = en_q;
  assign key_idx_o   = idx_q;
  assign key_vld_o   = vld_q;

endmodule

// File: tb/tb_piano_voice_sched.sv
// Testbench for piano_voice_sched: directed scenarios plus a randomized
// key sequence checked against a held-set / last-press reference model.
module tb_piano_voice_sched;
  import piano_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  keys_i;
  logic [15:0] tone_hp_o;
  logic        tone_load_o;
  logic        tone_ack_i = 1'b0;
  logic        tone_en_o;
  logic [2:0]  key_idx_o;
  logic        key_vld_o;

  int n_chk  = 0;
  int n_pass = 0;

  int EXP_HP [8] = '{19111, 17026, 15169, 14317,
                     12755, 11364, 10124, 9556};

  always #5 clk = ~clk;

  piano_voice_sched #(
    .NUM_KEYS  (8),
    .CNT_W     (16),
    .SAMPLE_DIV(4),
    .DB_SAMPLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .keys_i     (keys_i),
    .tone_hp_o  (tone_hp_o),
    .tone_load_o(tone_load_o),
    .tone_ack_i (tone_ack_i),
    .tone_en_o  (tone_en_o),
    .key_idx_o  (key_idx_o),
    .key_vld_o  (key_vld_o)
  );

  bit ack_auto  = 1'b1;
  bit ack_force = 1'b0;
  int ack_delay = 1;
  int wcnt      = 0;

  // Tone generator stand-in: acks after ack_delay load cycles.
  always @(negedge clk) begin
    if (ack_force) begin
      tone_ack_i = 1'b1;
    end else if (ack_auto && tone_load_o) begin
      if (wcnt >= ack_delay) begin
        tone_ack_i = 1'b1;
        wcnt = 0;
      end else begin
        tone_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      tone_ack_i = 1'b0;
      wcnt = 0;
    end
  end

  logic        prev_load = 1'b0;
  logic [15:0] prev_hp   = '0;
  int          hold_err  = 0;
  int          hold_cnt  = 0;

  always @(negedge clk) begin
    if (tone_load_o && prev_load) begin
      hold_cnt++;
      if (tone_hp_o !== prev_hp) hold_err++;
    end
    prev_load = tone_load_o;
    prev_hp   = tone_hp_o;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_load(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tone_load_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_len(input int max, output int n);
    n = 0;
    while (tone_load_o && n < max) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena = 1'b1;
    keys_i = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(100);
    n_chk++;
    if (tone_load_o !== 1'b0)
      $display("FAIL reset_load got=%b exp=0", tone_load_o);
    else n_pass++;
    n_chk++;
    if (tone_en_o !== 1'b0)
      $display("FAIL reset_en got=%b exp=0", tone_en_o);
    else n_pass++;
    n_chk++;
    if (key_vld_o !== 1'b0)
      $display("FAIL reset_vld got=%b exp=0", key_vld_o);
    else n_pass++;
    n_chk++;
    if (tone_hp_o !== 16'd0)
      $display("FAIL reset_hp got=%0d exp=0", tone_hp_o);
    else n_pass++;
    n_chk++;
    if (key_idx_o !== 3'd0)
      $display("FAIL reset_idx got=%0d exp=0", key_idx_o);
    else n_pass++;
    n_chk++;
    if (dut.state_q !== S_IDLE)
      $display("FAIL reset_state got=%0d exp=%0d",
               dut.state_q, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_single_press;
    int c, n;
    ack_delay = 1;
    keys_i = 8'h01;
    c = 0;
    while (!dut.lvl[0] && c < 60) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (dut.lvl[0] !== 1'b1)
      $display("FAIL single_debounce got=%b exp=1", dut.lvl[0]);
    else n_pass++;
    c = 0;
    while (!tone_load_o && c < 10) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (c != 2)
      $display("FAIL single_latency got=%0d exp=2", c);
    else n_pass++;
    n_chk++;
    if (tone_hp_o !== 16'(EXP_HP[0]))
      $display("FAIL single_hp got=%0d exp=%0d",
               tone_hp_o, EXP_HP[0]);
    else n_pass++;
    n_chk++;
    if (tone_en_o !== 1'b0)
      $display("FAIL single_en_early got=%b exp=0", tone_en_o);
    else n_pass++;
    load_len(50, n);
    n_chk++;
    if (n != 2)
      $display("FAIL single_load_len got=%0d exp=2", n);
    else n_pass++;
    cyc(2);
    n_chk++;
    if ({tone_en_o, key_vld_o, key_idx_o} !== {1'b1, 1'b1, 3'd0})
      $display("FAIL single_play got=%b%b/%0d exp=11/0",
               tone_en_o, key_vld_o, key_idx_o);
    else n_pass++;
  endtask

  task automatic test_press_over;
    bit ok;
    int n;
    keys_i = 8'h21;
    wait_load(60, ok);
    n_chk++;
    if (!ok || tone_hp_o !== 16'(EXP_HP[5]))
      $display("FAIL over_hp ok=%b got=%0d exp=%0d",
               ok, tone_hp_o, EXP_HP[5]);
    else n_pass++;
    n_chk++;
    if (tone_en_o !== 1'b1)
      $display("FAIL over_en_glide got=%b exp=1", tone_en_o);
    else n_pass++;
    load_len(50, n);
    cyc(2);
    n_chk++;
    if (key_idx_o !== 3'd5 || tone_en_o !== 1'b1)
      $display("FAIL over_idx got=%0d/%b exp=5/1",
               key_idx_o, tone_en_o);
    else n_pass++;
    keys_i = 8'h01;
    wait_load(60, ok);
    n_chk++;
    if (!ok || tone_hp_o !== 16'(EXP_HP[0]))
      $display("FAIL over_back_hp ok=%b got=%0d exp=%0d",
               ok, tone_hp_o, EXP_HP[0]);
    else n_pass++;
    load_len(50, n);
    cyc(2);
    n_chk++;
    if (key_idx_o !== 3'd0)
      $display("FAIL over_back_idx got=%0d exp=0", key_idx_o);
    else n_pass++;
  endtask

  task automatic test_glitch;
    bit seen, lseen;
    seen = 1'b0;
    lseen = 1'b0;
    keys_i = 8'h09;
    cyc(3);
    keys_i = 8'h01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tone_load_o) seen = 1'b1;
      if (dut.lvl[3]) lseen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL glitch_load got=%b exp=0", seen);
    else n_pass++;
    n_chk++;
    if (lseen !== 1'b0)
      $display("FAIL glitch_level got=%b exp=0", lseen);
    else n_pass++;
    n_chk++;
    if (key_idx_o !== 3'd0 || tone_en_o !== 1'b1)
      $display("FAIL glitch_play got=%0d/%b exp=0/1",
               key_idx_o, tone_en_o);
    else n_pass++;
  endtask

  task automatic test_ack_ignored;
    bit seen;
    seen = 1'b0;
    ack_force = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tone_load_o) seen = 1'b1;
    end
    ack_force = 1'b0;
    cyc(2);
    n_chk++;
    if (seen !== 1'b0 || dut.state_q !== S_PLAY || tone_en_o !== 1'b1)
      $display("FAIL ack_ignored load=%b st=%0d en=%b exp=0/%0d/1",
               seen, dut.state_q, tone_en_o, S_PLAY);
    else n_pass++;
  endtask

  task automatic test_simul;
    bit ok;
    int n;
    keys_i = 8'h00;
    cyc(40);
    n_chk++;
    if (tone_en_o !== 1'b0 || key_vld_o !== 1'b0)
      $display("FAIL simul_idle got=%b%b exp=00", tone_en_o, key_vld_o);
    else n_pass++;
    ack_delay = 10;
    keys_i = 8'h44;
    wait_load(60, ok);
    n_chk++;
    if (!ok || tone_hp_o !== 16'(EXP_HP[6]))
      $display("FAIL simul_hp ok=%b got=%0d exp=%0d",
               ok, tone_hp_o, EXP_HP[6]);
    else n_pass++;
    keys_i = 8'h04;
    load_len(60, n);
    n_chk++;
    if (n != 11)
      $display("FAIL simul_load_len got=%0d exp=11", n);
    else n_pass++;
    n_chk++;
    if (hold_err !== 0)
      $display("FAIL simul_hold got=%0d exp=0", hold_err);
    else n_pass++;
    ack_delay = 1;
    wait_load(40, ok);
    n_chk++;
    if (!ok || tone_hp_o !== 16'(EXP_HP[2]))
      $display("FAIL simul_reload ok=%b got=%0d exp=%0d",
               ok, tone_hp_o, EXP_HP[2]);
    else n_pass++;
    load_len(50, n);
    cyc(2);
    n_chk++;
    if (key_idx_o !== 3'd2 || tone_en_o !== 1'b1)
      $display("FAIL simul_idx got=%0d/%b exp=2/1",
               key_idx_o, tone_en_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    int n;
    ack_auto = 1'b0;
    keys_i = 8'h10;
    wait_load(60, ok);
    n_chk++;
    if (!ok || tone_hp_o !== 16'(EXP_HP[4]))
      $display("FAIL rstw_hp ok=%b got=%0d exp=%0d",
               ok, tone_hp_o, EXP_HP[4]);
    else n_pass++;
    cyc(3);
    n_chk++;
    if (tone_load_o !== 1'b1 || dut.state_q !== S_WAIT_ACK)
      $display("FAIL rstw_wait got=%b/%0d exp=1/%0d",
               tone_load_o, dut.state_q, S_WAIT_ACK);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (tone_load_o !== 1'b0 || tone_en_o !== 1'b0)
      $display("FAIL rstw_async got=%b%b exp=00",
               tone_load_o, tone_en_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ack_auto = 1'b1;
    ack_delay = 0;
    wait_load(60, ok);
    n_chk++;
    if (!ok || tone_hp_o !== 16'(EXP_HP[4]) || tone_en_o !== 1'b0)
      $display("FAIL rstw_restart ok=%b hp=%0d en=%b exp=%0d/0",
               ok, tone_hp_o, tone_en_o, EXP_HP[4]);
    else n_pass++;
    load_len(50, n);
    n_chk++;
    if (n != 1)
      $display("FAIL rstw_ack0_len got=%0d exp=1", n);
    else n_pass++;
    cyc(2);
    n_chk++;
    if (key_idx_o !== 3'd4 || tone_en_o !== 1'b1)
      $display("FAIL rstw_play got=%0d/%b exp=4/1",
               key_idx_o, tone_en_o);
    else n_pass++;
  endtask

  task automatic test_ena;
    bit ok;
    int n;
    ena = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({tone_load_o, tone_en_o, key_vld_o, key_idx_o, tone_hp_o}
        !== '0)
      $display("FAIL ena_clear got=%b%b%b/%0d/%0d exp=000/0/0",
               tone_load_o, tone_en_o, key_vld_o,
               key_idx_o, tone_hp_o);
    else n_pass++;
    ena = 1'b1;
    ack_delay = 2;
    wait_load(60, ok);
    load_len(50, n);
    cyc(2);
    n_chk++;
    if (!ok || key_idx_o !== 3'd4 || tone_en_o !== 1'b1)
      $display("FAIL ena_resume ok=%b got=%0d/%b exp=4/1",
               ok, key_idx_o, tone_en_o);
    else n_pass++;
  endtask

  task automatic test_random;
    bit [7:0] held;
    int sel, k, cnt;
    keys_i = 8'h00;
    cyc(40);
    held = '0;
    sel = -1;
    for (int it = 0; it < 14; it++) begin
      ack_delay = $urandom_range(0, 5);
      cnt = $countones(held);
      if (cnt == 0 || (cnt < 8 && ($urandom % 2) == 0)) begin
        k = $urandom_range(0, 7);
        while (held[k]) k = (k + 1) % 8;
        held[k] = 1'b1;
        sel = k;
      end else begin
        k = $urandom_range(0, 7);
        while (!held[k]) k = (k + 1) % 8;
        held[k] = 1'b0;
        if (sel == k) begin
          sel = -1;
          for (int j = 7; j >= 0; j--)
            if (held[j]) sel = j;
        end
      end
      keys_i = held;
      cyc(45);
      n_chk++;
      if (sel >= 0) begin
        if (tone_en_o !== 1'b1 || key_vld_o !== 1'b1 ||
            key_idx_o !== 3'(sel) || tone_hp_o !== 16'(EXP_HP[sel]) ||
            tone_load_o !== 1'b0)
          $display("FAIL rand_%0d keys=%h got=%b%b/%0d/%0d exp=11/%0d/%0d",
                   it, held, tone_en_o, key_vld_o, key_idx_o,
                   tone_hp_o, sel, EXP_HP[sel]);
        else n_pass++;
      end else begin
        if (tone_en_o !== 1'b0 || key_vld_o !== 1'b0 ||
            tone_load_o !== 1'b0)
          $display("FAIL rand_%0d keys=%h got=%b%b%b exp=000",
                   it, held, tone_en_o, key_vld_o, tone_load_o);
        else n_pass++;
      end
    end
    n_chk++;
    if (hold_cnt == 0 || hold_err != 0)
      $display("FAIL rand_hold cnt=%0d err=%0d exp=>0/0",
               hold_cnt, hold_err);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_press();
    test_press_over();
    test_glitch();
    test_ack_ignored();
    test_simul();
    test_reset_mid_wait();
    test_ena();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
